// File: rtl/ql_reserved_pkg.sv
// Shared types and constants for the fabric QuickLogic-reserved register block.
package ql_reserved_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DRAIN = 2'd2
    } to_state_t;

    localparam logic [6:0] DEF_CTRL_ADR      = 7'h7C;
    localparam logic [6:0] DEF_STATUS_ADR    = 7'h7D;
    localparam logic [6:0] DEF_CUST_PROD_ADR = 7'h7E;
    localparam logic [6:0] DEF_REVISIONS_ADR = 7'h7F;

    localparam int unsigned CTRL_IRQ_EN_BIT = 30;
    localparam int unsigned CTRL_TO_EN_BIT  = 31;

    localparam int unsigned STAT_FLAG_BIT = 31;
    localparam int unsigned STAT_CNT_LSB  = 16;
    localparam int unsigned STAT_WE_BIT   = 15;
    localparam int unsigned TO_CNT_W      = 8;

    // Saturating increment for the timeout event counter
    function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
        return (v == '1) ? v : v + TO_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ql_reserved_timeout_fsm.sv
// Default-acknowledge timeout state machine: counts down while a fabric cycle
// is outstanding and requests a default ack if no slave answers in time.
module ql_reserved_timeout_fsm
    import ql_reserved_pkg::*;
#(
    parameter int unsigned CNTR_WIDTH = 4
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  ack_i,
    input  logic [CNTR_WIDTH-1:0] timeout_i,
    input  logic                  to_en_i,
    output logic                  def_ack_nxt_o
);

    to_state_t             state;
    logic [CNTR_WIDTH-1:0] cntr;
    logic                  enabled;

    assign enabled = to_en_i & (timeout_i != '0);

    // Any slave ack in the final count cycle takes priority over the default ack
    assign def_ack_nxt_o = (state == ST_COUNT) & (cntr == CNTR_WIDTH'(1)) & ~ack_i;

    // State and down-counter; the counter reloads only while idle, so a new
    // timeout value never disturbs a count already in progress
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state <= ST_IDLE;
            cntr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cntr <= timeout_i;
                    if (cyc_i & stb_i & enabled)
                        state <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (ack_i)
                        state <= ST_IDLE;
                    else if (cntr == CNTR_WIDTH'(1))
                        state <= ST_DRAIN;
                    else
                        cntr <= cntr - CNTR_WIDTH'(1);
                end
                ST_DRAIN: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fabric_ql_reserved_ctl.sv
// Fabric QuickLogic-reserved registers: ID/revision readback, control and
// sticky timeout status, default-ack timeout and timeout interrupt.
// Optional build macro QL_RESERVED_ADR_LOG_EN adds capture of the address and
// write flag of the last timed-out access into STATUS.
module fabric_ql_reserved_ctl
    import ql_reserved_pkg::*;
#(
    parameter int unsigned            ADDRWIDTH            = 7,
    parameter int unsigned            DATAWIDTH            = 32,
    parameter logic [ADDRWIDTH-1:0]   CTRL_ADR             = ADDRWIDTH'(DEF_CTRL_ADR),
    parameter logic [ADDRWIDTH-1:0]   STATUS_ADR           = ADDRWIDTH'(DEF_STATUS_ADR),
    parameter logic [ADDRWIDTH-1:0]   CUST_PROD_ADR        = ADDRWIDTH'(DEF_CUST_PROD_ADR),
    parameter logic [ADDRWIDTH-1:0]   REVISIONS_ADR        = ADDRWIDTH'(DEF_REVISIONS_ADR),
    parameter logic [7:0]             CUSTOMER_ID          = 8'h01,
    parameter logic [7:0]             PRODUCT_ID           = 8'h00,
    parameter logic [15:0]            MAJOR_REV            = 16'h0002,
    parameter logic [15:0]            MINOR_REV            = 16'h0000,
    parameter logic [DATAWIDTH-1:0]   DEF_REG_VALUE        = 32'hDEF_FAB_AC,
    parameter int unsigned            CNTR_WIDTH           = 4,
    parameter int unsigned            DEFAULT_CNTR_TIMEOUT = 7
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic [ADDRWIDTH-1:0]  WBs_ADR_i,
    input  logic                  WBs_CYC_QL_Reserved_i,
    input  logic                  WBs_CYC_i,
    input  logic                  WBs_STB_i,
    input  logic                  WBs_WE_i,
    input  logic [DATAWIDTH-1:0]  WBs_DAT_i,
    input  logic                  WBs_ACK_i,
    output logic [DATAWIDTH-1:0]  WBs_DAT_o,
    output logic                  WBs_ACK_o,
    output logic                  Timeout_Irq_o
);

    logic                  ack_q;
    logic                  res_ack_nxt;
    logic                  def_ack_nxt;
    logic                  wr_commit;
    logic                  status_clr;
    logic [CNTR_WIDTH-1:0] wr_timeout;

    logic [CNTR_WIDTH-1:0] ctrl_timeout;
    logic                  ctrl_irq_en;
    logic                  ctrl_to_en;

    logic                  to_flag;
    logic [TO_CNT_W-1:0]   to_cnt;
    logic                  irq_q;
    logic                  unused_wdat;

`ifdef QL_RESERVED_ADR_LOG_EN
    logic [ADDRWIDTH-1:0]  log_adr;
    logic                  log_we;
`endif

    assign res_ack_nxt = WBs_CYC_QL_Reserved_i & WBs_STB_i & ~ack_q;
    assign wr_commit   = res_ack_nxt & WBs_WE_i;
    assign status_clr  = wr_commit & (WBs_ADR_i == STATUS_ADR) & WBs_DAT_i[STAT_FLAG_BIT];
    assign wr_timeout  = WBs_DAT_i[CNTR_WIDTH-1:0];
    assign unused_wdat = ^WBs_DAT_i;

    assign WBs_ACK_o     = ack_q;
    assign Timeout_Irq_o = irq_q;

    ql_reserved_timeout_fsm #(
        .CNTR_WIDTH (CNTR_WIDTH)
    ) u_timeout_fsm (
        .WBs_CLK_i     (WBs_CLK_i),
        .WBs_RST_i     (WBs_RST_i),
        .cyc_i         (WBs_CYC_i),
        .stb_i         (WBs_STB_i),
        .ack_i         (WBs_ACK_i),
        .timeout_i     (ctrl_timeout),
        .to_en_i       (ctrl_to_en),
        .def_ack_nxt_o (def_ack_nxt)
    );

    // Combined acknowledge: reserved-register ack or default timeout ack
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            ack_q <= 1'b0;
        else
            ack_q <= res_ack_nxt | def_ack_nxt;
    end

    // Control register; a timeout of 1 is promoted to 2
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            ctrl_timeout <= CNTR_WIDTH'(DEFAULT_CNTR_TIMEOUT);
            ctrl_irq_en  <= 1'b0;
            ctrl_to_en   <= 1'b1;
        end else if (wr_commit && (WBs_ADR_i == CTRL_ADR)) begin
            ctrl_timeout <= (wr_timeout == CNTR_WIDTH'(1)) ? CNTR_WIDTH'(2) : wr_timeout;
            ctrl_irq_en  <= WBs_DAT_i[CTRL_IRQ_EN_BIT];
            ctrl_to_en   <= WBs_DAT_i[CTRL_TO_EN_BIT];
        end
    end

    // Sticky timeout flag and saturating event count; a timeout on the same
    // edge as a clear restarts the count at 1 instead of losing the event
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            to_flag <= 1'b0;
            to_cnt  <= '0;
        end else if (def_ack_nxt) begin
            to_flag <= 1'b1;
            to_cnt  <= status_clr ? TO_CNT_W'(1) : sat_inc(to_cnt);
        end else if (status_clr) begin
            to_flag <= 1'b0;
            to_cnt  <= '0;
        end
    end

`ifdef QL_RESERVED_ADR_LOG_EN
    // Capture address and direction of the access that timed out
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            log_adr <= '0;
            log_we  <= 1'b0;
        end else if (def_ack_nxt) begin
            log_adr <= WBs_ADR_i;
            log_we  <= WBs_WE_i;
        end
    end
`endif

    // Registered timeout interrupt
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            irq_q <= 1'b0;
        else
            irq_q <= to_flag & ctrl_irq_en;
    end

    // Combinational read mux on the current address
    always_comb begin
        WBs_DAT_o = DEF_REG_VALUE;
        if (WBs_ADR_i == CTRL_ADR) begin
            WBs_DAT_o                   = '0;
            WBs_DAT_o[CTRL_TO_EN_BIT]   = ctrl_to_en;
            WBs_DAT_o[CTRL_IRQ_EN_BIT]  = ctrl_irq_en;
            WBs_DAT_o[CNTR_WIDTH-1:0]   = ctrl_timeout;
        end else if (WBs_ADR_i == STATUS_ADR) begin
            WBs_DAT_o                              = '0;
            WBs_DAT_o[STAT_FLAG_BIT]               = to_flag;
            WBs_DAT_o[STAT_CNT_LSB +: TO_CNT_W]    = to_cnt;
`ifdef QL_RESERVED_ADR_LOG_EN
            WBs_DAT_o[STAT_WE_BIT]                 = log_we;
            WBs_DAT_o[ADDRWIDTH-1:0]               = log_adr;
`endif
        end else if (WBs_ADR_i == CUST_PROD_ADR) begin
            WBs_DAT_o = {16'h0000, CUSTOMER_ID, PRODUCT_ID};
        end else if (WBs_ADR_i == REVISIONS_ADR) begin
            WBs_DAT_o = {MAJOR_REV, MINOR_REV};
        end
    end

endmodule

// File: tb/tb_fabric_ql_reserved_ctl.sv
// Directed self-checking bench for fabric_ql_reserved_ctl.
// Expected STATUS values follow QL_RESERVED_ADR_LOG_EN when it is defined.
module tb_fabric_ql_reserved_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  adr = '0;
    logic        ql_cyc = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdat = '0;
    logic        ext_ack = 1'b0;
    logic        ack_in;
    logic [31:0] rdat;
    logic        ack_out;
    logic        irq;

    int          n_checks = 0;
    int          n_pass = 0;

    assign ack_in = ack_out | ext_ack;

    always #5 clk = ~clk;

    fabric_ql_reserved_ctl dut (
        .WBs_CLK_i             (clk),
        .WBs_RST_i             (rst),
        .WBs_ADR_i             (adr),
        .WBs_CYC_QL_Reserved_i (ql_cyc),
        .WBs_CYC_i             (cyc),
        .WBs_STB_i             (stb),
        .WBs_WE_i              (we),
        .WBs_DAT_i             (wdat),
        .WBs_ACK_i             (ack_in),
        .WBs_DAT_o             (rdat),
        .WBs_ACK_o             (ack_out),
        .Timeout_Irq_o         (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [6:0] a, output logic [31:0] d);
        adr = a;
        #1;
        d = rdat;
    endtask

    task automatic reg_access(input logic w, input logic [6:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output int lat);
        lat = 0;
        ql_cyc = 1'b1; cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        do begin
            tick();
            lat++;
        end while (!ack_out && lat < 20);
        rd = rdat;
        ql_cyc = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic fab_access(input logic [6:0] a, input int max_cyc,
                              output int lat, output logic got, output logic irq_at_ack);
        lat = 0; got = 1'b0; irq_at_ack = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        while (!got && lat < max_cyc) begin
            tick();
            lat++;
            if (ack_out) begin
                got = 1'b1;
                irq_at_ack = irq;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          acks;
        logic        got;
        logic        irq_a;
        logic [31:0] st_one, st_two, st_clr, st_sat, st_race;

`ifdef QL_RESERVED_ADR_LOG_EN
        st_one  = 32'h8001_0010;
        st_two  = 32'h8002_0010;
        st_clr  = 32'h0000_0010;
        st_sat  = 32'h80FF_0010;
        st_race = 32'h8001_807D;
`else
        st_one  = 32'h8001_0000;
        st_two  = 32'h8002_0000;
        st_clr  = 32'h0000_0000;
        st_sat  = 32'h80FF_0000;
        st_race = 32'h8001_0000;
`endif

        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst_ack", {31'd0, ack_out}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        peek(7'h7C, d); check_eq("rst_ctrl", d, 32'h8000_0007);
        peek(7'h7D, d); check_eq("rst_status", d, 32'h0000_0000);
        peek(7'h10, d); check_eq("undef_read", d, 32'hDEFF_ABAC);

        // ID reads with single-cycle reserved ack
        reg_access(1'b0, 7'h7E, '0, d, lat);
        check_eq("cust_prod", d, 32'h0000_0100);
        check_eq("cust_prod_lat", lat, 1);
        reg_access(1'b0, 7'h7F, '0, d, lat);
        check_eq("revisions", d, 32'h0002_0000);
        check_eq("revisions_lat", lat, 1);
        check_eq("res_ack_pulse", {31'd0, ack_out}, 32'd0);

        // Default ack after TIMEOUT+1 cycles
        fab_access(7'h10, 20, lat, got, irq_a);
        check_eq("def_ack_got", {31'd0, got}, 32'd1);
        check_eq("def_ack_lat", lat, 8);
        check_eq("def_ack_pulse", {31'd0, ack_out}, 32'd0);
        peek(7'h7D, d); check_eq("status_after_to", d, st_one);
        check_eq("irq_disabled", {31'd0, irq}, 32'd0);

        // TIMEOUT=1 is stored as 2
        reg_access(1'b1, 7'h7C, 32'h8000_0001, d, lat);
        peek(7'h7C, d); check_eq("ctrl_to1", d, 32'h8000_0002);
        fab_access(7'h10, 20, lat, got, irq_a);
        check_eq("to2_lat", lat, 3);

        // Status writes without bit31 are ignored; bit31 clears
        reg_access(1'b1, 7'h7D, 32'h7FFF_FFFF, d, lat);
        peek(7'h7D, d); check_eq("status_ignored_wr", d, st_two);
        reg_access(1'b1, 7'h7D, 32'h8000_0000, d, lat);
        peek(7'h7D, d); check_eq("status_cleared", d, st_clr);

        // Programmed timeout and interrupt
        reg_access(1'b1, 7'h7C, 32'hC000_0003, d, lat);
        peek(7'h7C, d); check_eq("ctrl_c3", d, 32'hC000_0003);
        check_eq("irq_pre", {31'd0, irq}, 32'd0);
        fab_access(7'h10, 20, lat, got, irq_a);
        check_eq("to3_lat", lat, 4);
        check_eq("irq_at_ack", {31'd0, irq_a}, 32'd0);
        check_eq("irq_after_ack", {31'd0, irq}, 32'd1);

        // Slave ack on the last count cycle wins over default ack
        cyc = 1'b1; stb = 1'b1; adr = 7'h10;
        tick(); tick(); tick();
        ext_ack = 1'b1;
        tick();
        check_eq("ack_i_wins", {31'd0, ack_out}, 32'd0);
        ext_ack = 1'b0; cyc = 1'b0; stb = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack_out) acks++;
        end
        check_eq("ack_i_no_late_ack", acks, 0);
        peek(7'h7D, d); check_eq("ack_i_status", d, st_one);

        // Saturation of the event counter
        reg_access(1'b1, 7'h7C, 32'h8000_0002, d, lat);
        reg_access(1'b1, 7'h7D, 32'h8000_0000, d, lat);
        for (int i = 0; i < 256; i++) begin
            fab_access(7'h10, 20, lat, got, irq_a);
            if (i == 254) begin
                peek(7'h7D, d); check_eq("status_255", d, st_sat);
            end
        end
        peek(7'h7D, d); check_eq("status_sat_256", d, st_sat);

        // Clear write on the same edge as a new timeout
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h7D; wdat = 32'h8000_0000;
        tick(); tick();
        ql_cyc = 1'b1;
        tick();
        check_eq("race_ack", {31'd0, ack_out}, 32'd1);
        ql_cyc = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check_eq("race_ack_pulse", {31'd0, ack_out}, 32'd0);
        tick();
        peek(7'h7D, d); check_eq("race_status", d, st_race);

        // Timeout disabled by TIMEOUT=0 and by TO_EN=0
        reg_access(1'b1, 7'h7C, 32'h8000_0000, d, lat);
        fab_access(7'h10, 20, lat, got, irq_a);
        check_eq("to0_no_ack", {31'd0, got}, 32'd0);
        reg_access(1'b1, 7'h7C, 32'h0000_0007, d, lat);
        fab_access(7'h10, 20, lat, got, irq_a);
        check_eq("toen0_no_ack", {31'd0, got}, 32'd0);

        // Reset in the middle of a count
        reg_access(1'b1, 7'h7C, 32'hC000_0005, d, lat);
        tick();
        check_eq("irq_before_rst", {31'd0, irq}, 32'd1);
        cyc = 1'b1; stb = 1'b1; adr = 7'h10;
        tick(); tick(); tick();
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0;
        #2;
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_out) acks++;
        end
        check_eq("rst_mid_no_ack", acks, 0);
        check_eq("rst_mid_irq", {31'd0, irq}, 32'd0);
        peek(7'h7D, d); check_eq("rst_mid_status", d, 32'h0000_0000);
        peek(7'h7C, d); check_eq("rst_mid_ctrl", d, 32'h8000_0007);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
